// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module : calc_pkg
// Brief  : Opcodes, error codes, FSM encoding and the power-of-ten helper
//          shared by the calculator arithmetic engine.
// Rev    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_DIV0 = 2'b10;

    // Wide enough for any WIDTH+1 limit the engine is built with; callers slice it.
    localparam int POW_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_ITER  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    function automatic logic [POW_W-1:0] pow10(input int n);
        logic [POW_W-1:0] r;
        r = POW_W'(1);
        for (int i = 0; i < n; i++) begin
            r = r * POW_W'(10);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module : calc_iter_muldiv
// Brief  : Shared one-bit-per-clock shift-add multiplier / restoring divider.
// Rev    : 1.0 - initial release
// ============================================================================
module calc_iter_muldiv #(
    parameter int WIDTH = 40
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic             busy_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_acc_d;
    logic [WIDTH-1:0] w_lo_d;

    // MUL: {acc,lo} is the product, lo starts as multiplier. DIV: acc is the
    // partial remainder, lo shifts the dividend out and the quotient in.
    always_comb begin
        w_add   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        w_shift = {acc_q, lo_q[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, b_q});
        w_diff  = w_shift[WIDTH-1:0] - b_q;
        w_acc_d = w_add[WIDTH:1];
        w_lo_d  = {w_add[0], lo_q[WIDTH-1:1]};
        if (div_q) begin
            w_acc_d = w_ge ? w_diff : w_shift[WIDTH-1:0];
            w_lo_d  = {lo_q[WIDTH-2:0], w_ge};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else if (i_clr) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (i_start) begin
            busy_q <= 1'b1;
            div_q  <= i_div;
            cnt_q  <= '0;
            acc_q  <= '0;
            lo_q   <= i_a;
            b_q    <= i_b;
        end else if (busy_q) begin
            acc_q <= w_acc_d;
            lo_q  <= w_lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    // High during the final step, so the result is complete at the next edge.
    assign o_done = busy_q && (cnt_q == LAST);
    assign o_hi   = acc_q;
    assign o_lo   = lo_q;

endmodule
`default_nettype wire

// File: rtl/calc_engine.sv
`default_nettype none
// ============================================================================
// Module : calc_engine
// Brief  : Multi-cycle signed-magnitude add/sub/mul/div with display-range check.
// Rev    : 1.0 - initial release
// ============================================================================
module calc_engine
    import calc_pkg::*;
#(
    parameter int WIDTH  = 40,
    parameter int DIGITS = 6
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_clr,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_s1,
    input  logic             i_s1_sign,
    input  logic [WIDTH-1:0] i_s2,
    input  logic             i_s2_sign,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_sign,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_err,
    output logic [1:0]       o_err_code
);

    localparam logic [POW_W-1:0] POS_FULL = pow10(DIGITS) - POW_W'(1);
    localparam logic [POW_W-1:0] NEG_FULL = pow10(DIGITS - 1) - POW_W'(1);
    localparam logic [WIDTH:0]   POS_LIM  = POS_FULL[WIDTH:0];
    localparam logic [WIDTH:0]   NEG_LIM  = NEG_FULL[WIDTH:0];

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             a_sign_q, b_sign_q;
    logic [WIDTH:0]   sum_q;
    logic             sum_sign_q;
    logic             iter_start_q;
    logic [WIDTH-1:0] result_q, rem_q;
    logic             sign_q, err_q, done_q;
    logic [1:0]       err_code_q;

    logic             w_accept;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_hi, w_lo;
    logic             w_b_eff_sign;
    logic [WIDTH:0]   w_sum_d;
    logic             w_sum_sign_d;
    logic [WIDTH:0]   w_mag;
    logic [WIDTH-1:0] w_rem;
    logic             w_raw_sign;
    logic             w_sign;
    logic             w_hi_ovf;
    logic             w_ovf;
    logic             w_div0;

    assign w_accept = (state_q == ST_IDLE) && i_start && !err_q && !i_clr;

    calc_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (i_clr),
        .i_start   (iter_start_q),
        .i_div     (op_q == OP_DIV),
        .i_a       (a_q),
        .i_b       (b_q),
        .o_done    (w_iter_done),
        .o_hi      (w_hi),
        .o_lo      (w_lo)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (w_accept) state_d = i_op[1] ? ST_ITER : ST_EXEC;
                ST_EXEC:  state_d = ST_CHECK;
                ST_ITER:  if (w_iter_done) state_d = ST_CHECK;
                ST_CHECK: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // SUB is ADD with the second operand's sign flipped.
    always_comb begin
        w_b_eff_sign = b_sign_q ^ (op_q == OP_SUB);
        w_sum_d      = {1'b0, a_q} + {1'b0, b_q};
        w_sum_sign_d = a_sign_q;
        if (a_sign_q != w_b_eff_sign) begin
            if (a_q >= b_q) begin
                w_sum_d      = {1'b0, a_q - b_q};
                w_sum_sign_d = a_sign_q;
            end else begin
                w_sum_d      = {1'b0, b_q - a_q};
                w_sum_sign_d = w_b_eff_sign;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            a_sign_q     <= 1'b0;
            b_sign_q     <= 1'b0;
            sum_q        <= '0;
            sum_sign_q   <= 1'b0;
            iter_start_q <= 1'b0;
        end else begin
            iter_start_q <= w_accept && i_op[1];
            if (w_accept) begin
                op_q     <= i_op;
                a_q      <= i_s1;
                b_q      <= i_s2;
                a_sign_q <= i_s1_sign;
                b_sign_q <= i_s2_sign;
            end
            if (state_q == ST_EXEC) begin
                sum_q      <= w_sum_d;
                sum_sign_q <= w_sum_sign_d;
            end
        end
    end

    // Range check: the limit depends on the sign after zero-forcing.
    always_comb begin
        w_mag      = sum_q;
        w_rem      = '0;
        w_raw_sign = sum_sign_q;
        w_hi_ovf   = 1'b0;
        case (op_q)
            OP_MUL: begin
                w_mag      = {1'b0, w_lo};
                w_raw_sign = a_sign_q ^ b_sign_q;
                w_hi_ovf   = |w_hi;
            end
            OP_DIV: begin
                w_mag      = {1'b0, w_lo};
                w_rem      = w_hi;
                w_raw_sign = a_sign_q ^ b_sign_q;
            end
            default: ;
        endcase
        w_sign = w_raw_sign && (w_mag != '0);
        w_ovf  = w_hi_ovf || (w_mag > (w_sign ? NEG_LIM : POS_LIM));
        w_div0 = (op_q == OP_DIV) && (b_q == '0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            result_q   <= '0;
            rem_q      <= '0;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            done_q     <= 1'b0;
        end else if (i_clr) begin
            result_q   <= '0;
            rem_q      <= '0;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_CHECK) begin
                done_q <= 1'b1;
                if (w_div0 || w_ovf) begin
                    result_q   <= '0;
                    rem_q      <= '0;
                    sign_q     <= 1'b0;
                    err_q      <= 1'b1;
                    err_code_q <= w_div0 ? ERR_DIV0 : ERR_OVF;
                end else begin
                    result_q <= w_mag[WIDTH-1:0];
                    rem_q    <= w_rem;
                    sign_q   <= w_sign;
                end
            end
        end
    end

    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_result   = result_q;
    assign o_sign     = sign_q;
    assign o_rem      = rem_q;
    assign o_err      = err_q;
    assign o_err_code = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_engine
// Brief  : Self-checking bench for calc_engine: vector table, corner
//          sequences and randomized operations against an arithmetic model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_calc_engine;

    localparam int W = 40;
    localparam int D = 6;

    logic         i_clk      = 1'b0;
    logic         i_reset_n  = 1'b0;
    logic         i_start    = 1'b0;
    logic         i_clr      = 1'b0;
    logic [1:0]   i_op       = 2'b00;
    logic [W-1:0] i_s1       = '0;
    logic         i_s1_sign  = 1'b0;
    logic [W-1:0] i_s2       = '0;
    logic         i_s2_sign  = 1'b0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_result;
    logic         o_sign;
    logic [W-1:0] o_rem;
    logic         o_err;
    logic [1:0]   o_err_code;

    always #5 i_clk = ~i_clk;

    calc_engine #(
        .WIDTH  (W),
        .DIGITS (D)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_start    (i_start),
        .i_clr      (i_clr),
        .i_op       (i_op),
        .i_s1       (i_s1),
        .i_s1_sign  (i_s1_sign),
        .i_s2       (i_s2),
        .i_s2_sign  (i_s2_sign),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_sign     (o_sign),
        .o_rem      (o_rem),
        .o_err      (o_err),
        .o_err_code (o_err_code)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic         as;
        logic [W-1:0] b;
        logic         bs;
        logic [W-1:0] res;
        logic         sign;
        logic [W-1:0] rem;
        logic         err;
        logic [1:0]   code;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input longint a, input logic as,
                                input longint b, input logic bs, input longint res,
                                input logic sign, input longint rem, input logic err,
                                input logic [1:0] code);
        vec_t v;
        v.op = op; v.a = W'(a); v.as = as; v.b = W'(b); v.bs = bs;
        v.res = W'(res); v.sign = sign; v.rem = W'(rem); v.err = err; v.code = code;
        return v;
    endfunction

    // Reference: signed integer arithmetic on wide values, then the display range rule.
    function automatic vec_t model(input logic [1:0] op, input logic [W-1:0] a, input logic as,
                                   input logic [W-1:0] b, input logic bs);
        vec_t v;
        logic signed [127:0] va, vb, r;
        logic [127:0] mag, rm, plim, nlim;
        logic neg;
        v.op = op; v.a = a; v.as = as; v.b = b; v.bs = bs;
        v.res = '0; v.sign = 1'b0; v.rem = '0; v.err = 1'b0; v.code = 2'b00;
        plim = 128'd1;
        for (int i = 0; i < D; i++) plim = plim * 128'd10;
        nlim = plim / 128'd10 - 128'd1;
        plim = plim - 128'd1;
        rm  = '0;
        mag = '0;
        neg = 1'b0;
        va = $signed({{(128-W){1'b0}}, a});
        vb = $signed({{(128-W){1'b0}}, b});
        if (as) va = -va;
        if (bs ^ (op == 2'b01)) vb = -vb;
        case (op)
            2'b00, 2'b01: begin
                r   = va + vb;
                neg = (r < 0);
                mag = neg ? -r : r;
            end
            2'b10: begin
                mag = {{(128-W){1'b0}}, a} * {{(128-W){1'b0}}, b};
                neg = as ^ bs;
            end
            default: begin
                neg = as ^ bs;
                if (b != '0) begin
                    mag = {{(128-W){1'b0}}, a / b};
                    rm  = {{(128-W){1'b0}}, a % b};
                end
            end
        endcase
        if (mag == '0) neg = 1'b0;
        if (op == 2'b11 && b == '0) begin
            v.err = 1'b1; v.code = 2'b10;
        end else if (mag > (neg ? nlim : plim)) begin
            v.err = 1'b1; v.code = 2'b01;
        end else begin
            v.res = mag[W-1:0]; v.sign = neg; v.rem = rm[W-1:0];
        end
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_mag();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 1500));
            1:       return W'($urandom_range(0, 999999));
            2:       return W'($urandom_range(0, 20));
            default: return r[W-1:0];
        endcase
    endfunction

    task automatic clr_pulse();
        i_clr = 1'b1;
        @(posedge i_clk); #1;
        i_clr = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input bit keep_err);
        int lat;
        i_op = v.op; i_s1 = v.a; i_s1_sign = v.as; i_s2 = v.b; i_s2_sign = v.bs;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start   = 1'b0;
        i_s1      = rnd_mag();
        i_s2      = rnd_mag();
        i_s1_sign = 1'($urandom_range(0, 1));
        i_s2_sign = 1'($urandom_range(0, 1));
        chk("busy_after_start", {63'd0, o_busy}, 64'd1);
        lat = 0;
        while (!o_done && lat < 200) begin
            @(posedge i_clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), v.op[1] ? 64'(W + 2) : 64'd2);
        chk("result", 64'(o_result), 64'(v.res));
        chk("sign", {63'd0, o_sign}, {63'd0, v.sign});
        chk("rem", 64'(o_rem), 64'(v.rem));
        chk("err", {63'd0, o_err}, {63'd0, v.err});
        chk("err_code", {62'd0, o_err_code}, {62'd0, v.code});
        @(posedge i_clk); #1;
        chk("done_one_cycle", {63'd0, o_done}, 64'd0);
        if (v.err && !keep_err) begin
            clr_pulse();
            chk("err_cleared", {63'd0, o_err}, 64'd0);
        end
    endtask

    vec_t tbl[12];
    int   busy_seen, done_seen;

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(2'b01, 30,     0, 45,     0, 15,     1, 0, 0, 2'b00);
        tbl[1]  = mk(2'b00, 20,     1, 20,     0, 0,      0, 0, 0, 2'b00);
        tbl[2]  = mk(2'b10, 999,    0, 1001,   0, 999999, 0, 0, 0, 2'b00);
        tbl[3]  = mk(2'b10, 1000,   0, 1000,   0, 0,      0, 0, 1, 2'b01);
        tbl[4]  = mk(2'b11, 100,    1, 7,      0, 14,     1, 2, 0, 2'b00);
        tbl[5]  = mk(2'b11, 5,      0, 0,      0, 0,      0, 0, 1, 2'b10);
        tbl[6]  = mk(2'b00, 99998,  1, 1,      1, 99999,  1, 0, 0, 2'b00);
        tbl[7]  = mk(2'b01, 0,      0, 999999, 0, 0,      0, 0, 1, 2'b01);
        tbl[8]  = mk(2'b11, 7,      1, 100,    0, 0,      0, 7, 0, 2'b00);
        tbl[9]  = mk(2'b10, 3,      1, 0,      0, 0,      0, 0, 0, 2'b00);
        tbl[10] = mk(2'b00, 999998, 0, 1,      0, 999999, 0, 0, 0, 2'b00);
        tbl[11] = mk(2'b00, 999999, 0, 1,      0, 0,      0, 0, 1, 2'b01);

        #23;
        chk("reset_busy", {63'd0, o_busy}, 64'd0);
        chk("reset_done", {63'd0, o_done}, 64'd0);
        chk("reset_err", {63'd0, o_err}, 64'd0);
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        apply_vec(mk(2'b00, 5, 0, 7, 0, 12, 0, 0, 0, 2'b00), 0);

        // Asynchronous reset in the middle of MUL 123*456.
        i_op = 2'b10; i_s1 = 123; i_s1_sign = 0; i_s2 = 456; i_s2_sign = 0; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        #3;
        i_reset_n = 1'b0;
        #1;
        chk("midreset_busy", {63'd0, o_busy}, 64'd0);
        chk("midreset_result", 64'(o_result), 64'd0);
        chk("midreset_done", {63'd0, o_done}, 64'd0);
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        apply_vec(mk(2'b00, 5, 0, 7, 0, 12, 0, 0, 0, 2'b00), 0);

        for (int i = 0; i < 12; i++) begin
            apply_vec(tbl[i], 0);
        end

        // Sticky error: further starts are ignored until cleared.
        apply_vec(mk(2'b00, 99999, 1, 1, 1, 0, 0, 0, 1, 2'b01), 1);
        i_op = 2'b00; i_s1 = 1; i_s1_sign = 0; i_s2 = 1; i_s2_sign = 0; i_start = 1'b1;
        busy_seen = 0; done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk); #1;
            if (i == 2) i_start = 1'b0;
            if (o_busy) busy_seen++;
            if (o_done) done_seen++;
        end
        chk("sticky_busy", 64'(busy_seen), 64'd0);
        chk("sticky_done", 64'(done_seen), 64'd0);
        chk("sticky_err", {63'd0, o_err}, 64'd1);
        chk("sticky_code", {62'd0, o_err_code}, 64'd1);
        clr_pulse();
        chk("clr_err", {63'd0, o_err}, 64'd0);
        chk("clr_code", {62'd0, o_err_code}, 64'd0);
        apply_vec(mk(2'b00, 1, 0, 1, 0, 2, 0, 0, 0, 2'b00), 0);

        // Start held high across a whole MUL: only one operation.
        i_op = 2'b10; i_s1 = 3; i_s1_sign = 0; i_s2 = 4; i_s2_sign = 0; i_start = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge i_clk); #1;
            if (i == 20) i_start = 1'b0;
            if (o_done) done_seen++;
        end
        chk("held_start_dones", 64'(done_seen), 64'd1);
        chk("held_start_result", 64'(o_result), 64'd12);

        // Clear and start together in IDLE.
        i_op = 2'b00; i_s1 = 8; i_s2 = 9; i_clr = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_clr = 1'b0; i_start = 1'b0;
        chk("clr_start_busy", {63'd0, o_busy}, 64'd0);
        chk("clr_start_result", 64'(o_result), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            if (o_done) done_seen++;
        end
        chk("clr_start_done", 64'(done_seen), 64'd0);

        // Clear aborts a running MUL without a done pulse.
        apply_vec(mk(2'b00, 100, 0, 23, 0, 123, 0, 0, 0, 2'b00), 0);
        i_op = 2'b10; i_s1 = 7; i_s2 = 8; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        clr_pulse();
        chk("abort_busy", {63'd0, o_busy}, 64'd0);
        chk("abort_result", 64'(o_result), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge i_clk); #1;
            if (o_done) done_seen++;
        end
        chk("abort_done", 64'(done_seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            logic         as, bs;
            op = 2'($urandom_range(0, 3));
            a  = rnd_mag();
            b  = rnd_mag();
            as = 1'($urandom_range(0, 1));
            bs = 1'($urandom_range(0, 1));
            apply_vec(model(op, a, as, b, bs), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
